// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked shifting with odd parity,
// stop and ACK check. Drives the shared PS2_CLK/PS2_DATA pins through open-drain enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned FW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_REQ, S_SHIFT, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic          par_q, par_d;
  logic          ack_q, ack_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          err_noack_q, err_noack_d;
  logic          err_timeout_q, err_timeout_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};

    // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = clk_sync_q[1];
      else                    fcnt_d = fcnt_q + FW'(1);
    end
    fall_d = filt_q & ~filt_d;

    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    tx_d          = tx_q;
    par_d         = par_q;
    ack_d         = ack_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_ok_d      = 1'b0;
    err_noack_d   = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_d      = tx_data;
          par_d     = ~^tx_data;
          cnt_d     = '0;
          bit_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_REQ;
      end
      S_REQ, S_SHIFT, S_WAIT_IDLE: begin
        // Timeout is checked first so it wins over a fall in the same cycle.
        if (cnt_q == TMO_LAST) begin
          clk_oe_d      = 1'b0;
          data_oe_d     = 1'b0;
          done_d        = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = fall_q ? '0 : cnt_q + CW'(1);
          if (state_q == S_REQ) begin
            if (fall_q) begin
              data_oe_d = ~tx_q[0];
              bit_d     = 4'd1;
              state_d   = S_SHIFT;
            end
          end else if (state_q == S_SHIFT) begin
            if (fall_q) begin
              bit_d = bit_q + 4'd1;
              if (bit_q <= 4'd7) begin
                data_oe_d = ~tx_q[bit_q[2:0]];
              end else if (bit_q == 4'd8) begin
                data_oe_d = ~par_q;
              end else if (bit_q == 4'd9) begin
                data_oe_d = 1'b0;
              end else begin
                ack_d     = ~data_sync_q[1];
                data_oe_d = 1'b0;
                state_d   = S_WAIT_IDLE;
              end
            end
          end else begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (filt_q && data_sync_q[1]) begin
              done_d      = 1'b1;
              ack_ok_d    = ack_q;
              err_noack_d = ~ack_q;
              state_d     = S_DONE;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      filt_q        <= 1'b1;
      fcnt_q        <= '0;
      fall_q        <= 1'b0;
      cnt_q         <= '0;
      bit_q         <= '0;
      tx_q          <= '0;
      par_q         <= 1'b0;
      ack_q         <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_ok_q      <= 1'b0;
      err_noack_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      filt_q        <= filt_d;
      fcnt_q        <= fcnt_d;
      fall_q        <= fall_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      tx_q          <= tx_d;
      par_q         <= par_d;
      ack_q         <= ack_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      done_q        <= done_d;
      ack_ok_q      <= ack_ok_d;
      err_noack_q   <= err_noack_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err_noack   = err_noack_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND pins decodes each frame,
// which is compared with the frame built arithmetically from the byte sent.
module tb_ps2_host_tx;

  localparam int HALF    = 30;
  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_NOCLK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe;
  logic       done, ack_ok, err_noack, err_timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int viol = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(200),
    .TIMEOUT_CYCLES(20000),
    .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .done(done), .ack_ok(ack_ok), .err_noack(err_noack), .err_timeout(err_timeout)
  );

  // Status flags must be quiet outside done, and exactly one must accompany done.
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      if ((int'(ack_ok) + int'(err_noack) + int'(err_timeout)) != 1) viol <= viol + 1;
    end else if (ack_ok || err_noack || err_timeout) begin
      viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = $countones(b);
    par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic dev_run(input int mode, input int stop_after, output logic [10:0] frame, output bit saw_req);
    frame   = '1;
    saw_req = 1'b0;
    for (int i = 0; i < 2000 && !saw_req; i++) begin
      @(negedge clk);
      if (ps2_clk_in && !ps2_data_in) saw_req = 1'b1;
    end
    if (!saw_req || mode == M_NOCLK) return;
    repeat (HALF) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == stop_after) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = ps2_data_in;
      if (k == 10 && mode == M_ACK) dev_data = 1'b0;
      if (k == 11) dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output logic a, output logic na, output logic tmo);
    bit seen;
    seen = 1'b0;
    a = 1'b0; na = 1'b0; tmo = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        a = ack_ok; na = err_noack; tmo = err_timeout;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      @(negedge clk);
      check("ready_after_done", tx_ready, 1);
    end
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit inject_dup, input logic [7:0] dup);
    logic [10:0] fr;
    bit req;
    int c0, oe_seen;
    logic a, na, tmo;
    @(negedge clk);
    check("tx_ready_idle", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("clk_oe_latency", ps2_clk_oe, 1);
    check("busy_after_accept", busy, 1);
    c0 = done_cnt;
    fork
      dev_run(mode, 0, fr, req);
      wait_done(5000, a, na, tmo);
      begin
        if (inject_dup) begin
          repeat (50) @(negedge clk);
          tx_data  = dup;
          tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    join
    check("dev_saw_req", req, 1);
    check("frame", fr, model_frame(b));
    check("ack_ok", a, (mode == M_ACK));
    check("err_noack", na, (mode == M_NOACK));
    check("err_timeout", tmo, 0);
    check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    if (inject_dup) begin
      oe_seen = 0;
      repeat (300) begin
        @(negedge clk);
        if (ps2_clk_oe) oe_seen++;
      end
      check("dup_not_queued", oe_seen, 0);
    end
    check("done_count", done_cnt - c0, 1);
  endtask

  task automatic timeout_test();
    int n;
    bit in_req, seen;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    in_req = 1'b0;
    for (int i = 0; i < 2000 && !in_req; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) in_req = 1'b1;
    end
    check("tmo_req_entered", in_req, 1);
    n = 0;
    seen = 1'b0;
    while (in_req && !seen && n < 25000) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check("tmo_cycles", n, 20000);
    check("tmo_flag", err_timeout, 1);
    check("tmo_ack_ok", ack_ok, 0);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    @(negedge clk);
    check("tmo_ready_next", tx_ready, 1);
  endtask

  task automatic reset_mid_frame();
    logic [10:0] fr;
    bit req;
    int c0;
    @(negedge clk);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    c0 = done_cnt;
    dev_run(M_ACK, 5, fr, req);
    check("rst_dev_req", req, 1);
    repeat (15) @(negedge clk);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_done", done_cnt - c0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    int rm;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_status", {done, ack_ok, err_noack, err_timeout}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hED, M_ACK, 1'b0, 8'h00);
    send(8'h00, M_ACK, 1'b0, 8'h00);
    send(8'hFF, M_ACK, 1'b0, 8'h00);
    send(8'hF4, M_NOACK, 1'b0, 8'h00);
    timeout_test();
    reset_mid_frame();
    send(8'hED, M_ACK, 1'b0, 8'h00);
    send(8'hA5, M_ACK, 1'b1, 8'h3C);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      rm = ($urandom_range(0, 1) == 0) ? M_ACK : M_NOACK;
      send(rb, rm, 1'b0, 8'h00);
    end

    repeat (5) @(negedge clk);
    check("flag_invariant", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
